// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: shared owner/size encodings for the sram-like CPU bus. Rev 1.0
`default_nettype none

package cpu_bus_pkg;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

`default_nettype wire

// File: rtl/sram_like_arbiter_owner_fifo.sv
// owner_fifo: in-order 1-bit owner tags for accepted, not-yet-returned transactions. Rev 1.0
`default_nettype none

module owner_fifo
  import cpu_bus_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  owner_e           push_owner,
  input  logic             pop,
  output owner_e           head_owner,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  owner_e     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;

  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);
  assign head_owner = mem[rd_ptr];
  assign do_pop     = pop & ~empty;
  // A simultaneous pop frees the slot, so a push is legal even when full.
  assign do_push    = push & (~full | do_pop);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_owner;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: shares one sram-like master port between inst and data requesters.
// Rev 1.0. Optional macro ARB_ROUND_ROBIN_EN selects round-robin instead of data-first priority.
`default_nettype none

module sram_like_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int OUTST_DEPTH = 2,
  parameter int CNT_W       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata,
  output logic        err_spurious
);

  owner_e grant, lock_owner, lock_owner_nxt, head_owner;
  logic   lock_vld, lock_vld_nxt;
  logic   gnt_req, full, empty, push, pop;
  logic [CNT_W-1:0] count;
  logic   unused_count;

`ifdef ARB_ROUND_ROBIN_EN
  owner_e last_grant;

  always_ff @(posedge clk) begin
    if (rst)       last_grant <= OWNER_INST;
    else if (push) last_grant <= grant;
  end
`endif

  always_comb begin
    grant = OWNER_DATA;
    if (lock_vld) begin
      grant = lock_owner;
    end else if (data_req && inst_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant = (last_grant == OWNER_INST) ? OWNER_DATA : OWNER_INST;
`else
      grant = OWNER_DATA;
`endif
    end else if (inst_req) begin
      grant = OWNER_INST;
    end
  end

  // With nothing granted the default grant is DATA, so the bus shows data_* with m_req low.
  assign gnt_req = (grant == OWNER_INST) ? inst_req : data_req;
  assign m_req   = gnt_req & ~full & ~rst;
  assign m_wr    = (grant == OWNER_INST) ? inst_wr    : data_wr;
  assign m_size  = (grant == OWNER_INST) ? inst_size  : data_size;
  assign m_addr  = (grant == OWNER_INST) ? inst_addr  : data_addr;
  assign m_wdata = (grant == OWNER_INST) ? inst_wdata : data_wdata;

  assign inst_addr_ok = m_addr_ok & m_req & (grant == OWNER_INST);
  assign data_addr_ok = m_addr_ok & m_req & (grant == OWNER_DATA);

  assign push = m_req & m_addr_ok;
  assign pop  = m_data_ok & ~empty;

  assign inst_data_ok = pop & ~rst & (head_owner == OWNER_INST);
  assign data_data_ok = pop & ~rst & (head_owner == OWNER_DATA);
  assign inst_rdata   = m_rdata;
  assign data_rdata   = m_rdata;

  // Lock holds the grant across a stalled handshake; it is kept while full blocks m_req.
  always_comb begin
    lock_vld_nxt   = lock_vld;
    lock_owner_nxt = lock_owner;
    if (m_req) begin
      lock_vld_nxt   = ~m_addr_ok;
      lock_owner_nxt = grant;
    end else if (!gnt_req) begin
      lock_vld_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_vld     <= 1'b0;
      lock_owner   <= OWNER_INST;
      err_spurious <= 1'b0;
    end else begin
      lock_vld   <= lock_vld_nxt;
      lock_owner <= lock_owner_nxt;
      if (m_data_ok && empty) err_spurious <= 1'b1;
    end
  end

  owner_fifo #(
    .DEPTH (OUTST_DEPTH),
    .CNT_W (CNT_W)
  ) u_owner_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_owner (grant),
    .pop        (pop),
    .head_owner (head_owner),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  assign unused_count = ^count;

endmodule

`default_nettype wire

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter: directed stimulus with a return-path scoreboard for sram_like_arbiter.
`default_nettype none

module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata;
  logic        m_addr_ok, m_data_ok;
  logic [31:0] m_rdata;
  logic        err_spurious;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        owner;
    logic [31:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  sram_like_arbiter #(.OUTST_DEPTH(2), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .err_spurious(err_spurious)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to the next cycle and leave inputs to be driven just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Drive one return beat and record which requester must see it.
  task automatic ret(input logic owner, input logic [31:0] rdata);
    m_data_ok = 1'b1;
    m_rdata   = rdata;
    exp_q.push_back('{owner: owner, rdata: rdata});
  endtask

  // Monitor: every data_ok must match the oldest expected return.
  always @(negedge clk) begin
    if (inst_data_ok || data_data_ok) begin
      exp_t e;
      checks++;
      if (inst_data_ok && data_data_ok) begin
        errors++;
        $display("FAIL both_data_ok: got inst=1 data=1 expected one at %0t", $time);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_data_ok: got inst=%0b data=%0b expected none at %0t",
                 inst_data_ok, data_data_ok, $time);
      end else begin
        e = exp_q.pop_front();
        if (data_data_ok !== e.owner ||
            (e.owner ? data_rdata : inst_rdata) !== e.rdata) begin
          errors++;
          $display("FAIL return: got owner=%0b rdata=0x%08h expected owner=%0b rdata=0x%08h at %0t",
                   data_data_ok, (data_data_ok ? data_rdata : inst_rdata), e.owner, e.rdata, $time);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    inst_req = 0; inst_wr = 0; inst_size = 2'b10; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 2'b10; data_addr = 0; data_wdata = 0;
    m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
    step();
    // Outputs forced low during reset regardless of inputs.
    inst_req = 1; data_req = 1; m_addr_ok = 1;
    sample();
    chk("rst_m_req", {31'd0, m_req}, 0);
    chk("rst_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 0);
    step();
    rst = 0; inst_req = 0; data_req = 0; m_addr_ok = 0;
    sample();
    chk("idle_m_req", {31'd0, m_req}, 0);
    chk("idle_err", {31'd0, err_spurious}, 0);

    // Single instruction read.
    step();
    inst_req = 1; inst_addr = 32'h1FC0_0000; m_addr_ok = 1;
    sample();
    chk("t1_m_addr", m_addr, 32'h1FC0_0000);
    chk("t1_inst_addr_ok", {31'd0, inst_addr_ok}, 1);
    chk("t1_data_addr_ok", {31'd0, data_addr_ok}, 0);
    step(); inst_req = 0; m_addr_ok = 0;
    step();
    step(); ret(1'b0, 32'h2408_0001);
    sample();
    chk("t1_inst_data_ok", {31'd0, inst_data_ok}, 1);
    step(); m_data_ok = 0;

`ifndef ARB_ROUND_ROBIN_EN
    // Simultaneous requests: data first, then inst.
    inst_req = 1; inst_addr = 32'h0000_1000; data_req = 1; data_addr = 32'h8000_2000;
    data_wr = 1; data_wdata = 32'hDEAD_BEEF; m_addr_ok = 1;
    sample();
    chk("t2_first_addr", m_addr, 32'h8000_2000);
    chk("t2_first_wdata", m_wdata, 32'hDEAD_BEEF);
    chk("t2_first_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd1);
    step(); data_req = 0; data_wr = 0;
    sample();
    chk("t2_second_addr", m_addr, 32'h0000_1000);
    chk("t2_second_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd2);
    step(); inst_req = 0; m_addr_ok = 0; ret(1'b1, 32'hAAAA_0001);
    step(); ret(1'b0, 32'hBBBB_0002);
    step(); m_data_ok = 0;
`endif

    // Lock: stalled inst handshake must not be pre-empted by data.
    inst_req = 1; inst_addr = 32'h0000_3000; data_addr = 32'h8000_4000;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) data_req = 1;
      sample();
      chk("t3_locked_addr", m_addr, 32'h0000_3000);
      chk("t3_locked_ok", {30'd0, inst_addr_ok, data_addr_ok}, 0);
      step();
    end
    m_addr_ok = 1;
    sample();
    chk("t3_inst_accept", {30'd0, inst_addr_ok, data_addr_ok}, 32'd2);
    step(); inst_req = 0;
    sample();
    chk("t3_data_addr", m_addr, 32'h8000_4000);
    chk("t3_data_accept", {30'd0, inst_addr_ok, data_addr_ok}, 32'd1);
    step(); data_req = 0; m_addr_ok = 0; ret(1'b0, 32'h1111_0003);
    step(); ret(1'b1, 32'h2222_0004);
    step(); m_data_ok = 0;

    // Outstanding limit of two.
    inst_req = 1; inst_addr = 32'h0000_5000; m_addr_ok = 1;
    sample(); chk("t4_acc0", {31'd0, inst_addr_ok}, 1);
    step();
    sample(); chk("t4_acc1", {31'd0, inst_addr_ok}, 1);
    step();
    sample();
    chk("t4_full_m_req", {31'd0, m_req}, 0);
    chk("t4_full_ok", {31'd0, inst_addr_ok}, 0);
    step(); ret(1'b0, 32'h3333_0005);
    sample(); chk("t4_pop_cycle_m_req", {31'd0, m_req}, 0);
    step(); m_data_ok = 0;
    sample();
    chk("t4_reassert_m_req", {31'd0, m_req}, 1);
    chk("t4_reassert_ok", {31'd0, inst_addr_ok}, 1);
    step(); inst_req = 0; m_addr_ok = 0; ret(1'b0, 32'h4444_0006);
    step(); ret(1'b0, 32'h5555_0007);
    step(); m_data_ok = 0;

    // Spurious return and reset recovery.
    m_data_ok = 1; m_rdata = 32'h6666_0008;
    sample();
    chk("t5_no_data_ok", {30'd0, inst_data_ok, data_data_ok}, 0);
    step(); m_data_ok = 0;
    sample(); chk("t5_err_set", {31'd0, err_spurious}, 1);
    step(); inst_req = 1; m_addr_ok = 1;
    sample(); chk("t5_preload", {31'd0, inst_addr_ok}, 1);
    step(); inst_req = 0; m_addr_ok = 0; rst = 1;
    step(); rst = 0;
    sample(); chk("t5_err_clear", {31'd0, err_spurious}, 0);
    step(); m_data_ok = 1;
    sample();
    chk("t5_owner_discarded", {30'd0, inst_data_ok, data_data_ok}, 0);
    step(); m_data_ok = 0;
    sample(); chk("t5_err_reset_count", {31'd0, err_spurious}, 1);

`ifdef ARB_ROUND_ROBIN_EN
    // Round-robin: alternate starting from DATA after reset.
    step(); rst = 1;
    step(); rst = 0;
    inst_req = 1; data_req = 1; inst_addr = 32'h0000_7000; data_addr = 32'h8000_7000;
    m_addr_ok = 1;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) ret((c % 2) == 0 ? 1'b0 : 1'b1, 32'h7700_0000 + 32'(c));
      sample();
      chk("rr_grant", m_addr, (c % 2) == 0 ? 32'h8000_7000 : 32'h0000_7000);
      step();
    end
    inst_req = 0; data_req = 0; m_addr_ok = 0; ret(1'b0, 32'h7700_0004);
    step(); m_data_ok = 0;
`endif

    step();
    step();
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
